priority_encoder_8x3: RTL and testbench



---
 rtl/priority_encoder_8x3_if.sv | 13 +
 rtl/priority_encoder_8x3.sv | 102 ++++++++++
 tb/tb_priority_encoder_8x3.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/priority_encoder_8x3_if.sv
// Request/issue bus of the 8x3 priority encoder: capture side (E, D),
// consumer ready (R) and the registered index/valid/busy outputs.
interface priority_encoder_8x3_if;
  logic       E;
  logic [7:0] D;
  logic       R;
  logic [2:0] A;
  logic       V;
  logic       B;

  modport master (output E, output D, output R, input A, input V, input B);
  modport slave  (input E, input D, input R, output A, output V, output B);
endinterface

// File: rtl/priority_encoder_8x3.sv
// Sequential 8-to-3 priority encoder: sticky pending register drained one
// index per valid/ready handshake, highest index first.
module priority_encoder_8x3 (
  input  logic                  clk,
  input  logic                  rst,
  priority_encoder_8x3_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] p_q, p_d;
  logic [2:0] a_q, a_d;
  logic       v_q, v_d;
  logic       b_q, b_d;
  logic       issue_s;
  logic [7:0] clr_s;

  function automatic logic [2:0] sel_idx(input logic [7:0] p);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

  // Next-state, issue decision and pending-register update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    v_d     = v_q;
    issue_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (p_q != 8'h00) begin
          issue_s = 1'b1;
          state_d = HOLD;
          v_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!bus.R) begin
          state_d = HOLD;
        end else if (p_q != 8'h00) begin
          // p_q already excludes the index sitting in A unless it was re-armed.
          issue_s = 1'b1;
        end else begin
          v_d     = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        v_d     = 1'b0;
      end
    endcase
    if (issue_s) begin
      a_d   = sel_idx(p_q);
      clr_s = onehot(sel_idx(p_q));
    end else begin
      clr_s = 8'h00;
    end
    p_d = (p_q & ~clr_s) | (bus.E ? bus.D : 8'h00);
    b_d = |p_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= 8'h00;
      a_q     <= 3'd0;
      v_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      v_q     <= v_d;
      b_q     <= b_d;
    end
  end

  assign bus.A = a_q;
  assign bus.V = v_q;
  assign bus.B = b_q;

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Directed bench for priority_encoder_8x3 with hand-computed expectations.
module tb_priority_encoder_8x3;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  priority_encoder_8x3_if pe_bus ();

  priority_encoder_8x3 dut (
    .clk (clk),
    .rst (rst),
    .bus (pe_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] a, input logic b);
    chk({tag, ".V"}, {7'd0, pe_bus.V}, {7'd0, v});
    if (v) chk({tag, ".A"}, {5'd0, pe_bus.A}, {5'd0, a});
    chk({tag, ".B"}, {7'd0, pe_bus.B}, {7'd0, b});
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    pe_bus.E = 1'b1;
    pe_bus.D = 8'hFF;
    pe_bus.R = 1'b1;

    // Reset ignores D/E
    tick();
    chk("rst1.A", {5'd0, pe_bus.A}, 8'h00);
    chk_out("rst1", 1'b0, 3'd0, 1'b0);
    tick();
    chk("rst2.A", {5'd0, pe_bus.A}, 8'h00);
    chk_out("rst2", 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk("post_rst.A", {5'd0, pe_bus.A}, 8'h00);
    chk_out("post_rst", 1'b0, 3'd0, 1'b0);

    // Single request
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b0000_0100;
    tick();
    chk_out("single_cap", 1'b0, 3'd0, 1'b1);
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("single_iss", 1'b1, 3'd2, 1'b0);
    tick();
    chk_out("single_end", 1'b0, 3'd0, 1'b0);

    // Ordered drain
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b1010_0101;
    tick();
    chk_out("drain_cap", 1'b0, 3'd0, 1'b1);
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("drain0", 1'b1, 3'd7, 1'b1);
    tick();
    chk_out("drain1", 1'b1, 3'd5, 1'b1);
    tick();
    chk_out("drain2", 1'b1, 3'd2, 1'b1);
    tick();
    chk_out("drain3", 1'b1, 3'd0, 1'b0);
    tick();
    chk_out("drain_end", 1'b0, 3'd0, 1'b0);

    // Backpressure
    pe_bus.R = 1'b0;
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b0000_1000;
    tick();
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("bp_iss", 1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("bp_hold", 1'b1, 3'd3, 1'b0);
    end
    pe_bus.R = 1'b1;
    tick();
    chk_out("bp_rel", 1'b0, 3'd0, 1'b0);

    // Enable gating
    pe_bus.E = 1'b0;
    pe_bus.D = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("gate", 1'b0, 3'd0, 1'b0);
    end
    pe_bus.D = 8'h00;

    // Re-arm on the handshake edge
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b0000_1000;
    tick();
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("rearm_iss1", 1'b1, 3'd3, 1'b0);
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b0000_1000;
    tick();
    chk_out("rearm_hs", 1'b0, 3'd0, 1'b1);
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("rearm_iss2", 1'b1, 3'd3, 1'b0);
    tick();
    chk_out("rearm_end", 1'b0, 3'd0, 1'b0);

    // Merge: D[3] asserted twice while pending
    pe_bus.R = 1'b0;
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b0001_0000;
    tick();
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("merge_iss4", 1'b1, 3'd4, 1'b0);
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b0000_1000;
    tick();
    chk_out("merge_cap1", 1'b1, 3'd4, 1'b1);
    tick();
    chk_out("merge_cap2", 1'b1, 3'd4, 1'b1);
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    pe_bus.R = 1'b1;
    tick();
    chk_out("merge_iss3", 1'b1, 3'd3, 1'b0);
    tick();
    chk_out("merge_end", 1'b0, 3'd0, 1'b0);

    // New bits during a handshake join only on the following edge
    pe_bus.R = 1'b0;
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b0000_0011;
    tick();
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("simul_iss1", 1'b1, 3'd1, 1'b1);
    pe_bus.R = 1'b1;
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b1000_0000;
    tick();
    chk_out("simul_iss0", 1'b1, 3'd0, 1'b1);
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("simul_iss7", 1'b1, 3'd7, 1'b0);
    tick();
    chk_out("simul_end", 1'b0, 3'd0, 1'b0);

    // Reset mid-operation
    pe_bus.R = 1'b0;
    pe_bus.E = 1'b1;
    pe_bus.D = 8'b1100_0000;
    tick();
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("midrst_iss", 1'b1, 3'd7, 1'b1);
    rst = 1'b1;
    pe_bus.E = 1'b1;
    pe_bus.D = 8'hFF;
    tick();
    chk("midrst.A", {5'd0, pe_bus.A}, 8'h00);
    chk_out("midrst", 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    pe_bus.E = 1'b0;
    pe_bus.D = 8'h00;
    tick();
    chk_out("midrst_after", 1'b0, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
